// File: rtl/mem_arbiter_if.sv
// Bundle between two memory requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding environment: the requesters plus the memory read-data return.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    // requester 0
    logic              req0;
    logic              we0;
    logic              lock0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;
    logic              err0;

    // requester 1
    logic              req1;
    logic              we1;
    logic              lock1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;
    logic              err1;

    // data memory port
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_writeData;
    logic              mem_memWrite;
    logic              mem_memRead;
    logic [DATA_W-1:0] mem_readData;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        output gnt0, rvalid0, rdata0, err0,
        input  req1, we1, lock1, addr1, wdata1,
        output gnt1, rvalid1, rdata1, err1,
        output mem_address, mem_writeData, mem_memWrite, mem_memRead,
        input  mem_readData
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0, err0,
        output req1, we1, lock1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1, err1,
        input  mem_address, mem_writeData, mem_memWrite, mem_memRead,
        output mem_readData
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Grants are combinational in the request cycle; read data returns one cycle
// later from the memory's registered output. A requester may lock the memory
// for consecutive accesses; a lock-age counter bounds how long it is held.
// Out-of-range quadword accesses are consumed without touching memory and
// answered with an error pulse.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 128,
    parameter int MAX_QW   = 2000,
    parameter int LOCK_MAX = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int               CNT_W    = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } state_t;

    // Quadword index above MAX_QW means the access must not reach memory.
    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] qw_idx;
        qw_idx = {4'b0000, addr[ADDR_W-1:4]};
        return (qw_idx > ADDR_W'(MAX_QW));
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic             ptr_r;        // 0: requester 0 wins a tie, 1: requester 1
    logic             ptr_s;
    logic [CNT_W-1:0] lock_cnt_r;
    logic [CNT_W-1:0] lock_cnt_s;

    logic             gnt0_s;
    logic             gnt1_s;
    logic             oor0_s;
    logic             oor1_s;
    logic             eff_lock0_s;  // lock request that actually counts
    logic             eff_lock1_s;

    logic             rd_pend0_r;   // read granted last cycle, data due now
    logic             rd_pend1_r;
    logic             err0_r;
    logic             err1_r;

    // Range check of both requesters and the lock bits that may take effect.
    always_comb begin
        oor0_s      = out_of_range(bus.addr0);
        oor1_s      = out_of_range(bus.addr1);
        eff_lock0_s = bus.lock0 & ~oor0_s;
        eff_lock1_s = bus.lock1 & ~oor1_s;
    end

    // Grant selection: lock owner only, else round-robin on a tie, else sole requester.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case (state_r)
                UNLOCKED: begin
                    if (bus.req0 && bus.req1) begin
                        if (ptr_r) begin
                            gnt1_s = 1'b1;
                        end else begin
                            gnt0_s = 1'b1;
                        end
                    end else begin
                        gnt0_s = bus.req0;
                        gnt1_s = bus.req1;
                    end
                end
                LOCKED0: begin
                    gnt0_s = bus.req0;
                end
                LOCKED1: begin
                    gnt1_s = bus.req1;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
    end

    // Next lock state, priority pointer and lock-age counter.
    always_comb begin
        state_s    = state_r;
        lock_cnt_s = lock_cnt_r;
        if (gnt0_s) begin
            ptr_s = 1'b1;
        end else if (gnt1_s) begin
            ptr_s = 1'b0;
        end else begin
            ptr_s = ptr_r;
        end

        case (state_r)
            UNLOCKED: begin
                lock_cnt_s = CNT_ZERO;
                if (gnt0_s && eff_lock0_s) begin
                    state_s = LOCKED0;
                end else if (gnt1_s && eff_lock1_s) begin
                    state_s = LOCKED1;
                end else begin
                    state_s = UNLOCKED;
                end
            end
            LOCKED0: begin
                if (lock_cnt_r == CNT_LAST) begin
                    // lock aged out: hand priority to the requester that waited
                    state_s    = UNLOCKED;
                    ptr_s      = 1'b1;
                    lock_cnt_s = CNT_ZERO;
                end else if (gnt0_s && !eff_lock0_s) begin
                    state_s    = UNLOCKED;
                    lock_cnt_s = CNT_ZERO;
                end else begin
                    state_s    = LOCKED0;
                    lock_cnt_s = lock_cnt_r + CNT_ONE;
                end
            end
            LOCKED1: begin
                if (lock_cnt_r == CNT_LAST) begin
                    state_s    = UNLOCKED;
                    ptr_s      = 1'b0;
                    lock_cnt_s = CNT_ZERO;
                end else if (gnt1_s && !eff_lock1_s) begin
                    state_s    = UNLOCKED;
                    lock_cnt_s = CNT_ZERO;
                end else begin
                    state_s    = LOCKED1;
                    lock_cnt_s = lock_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s    = UNLOCKED;
                lock_cnt_s = CNT_ZERO;
            end
        endcase
    end

    // Memory command and grant outputs for the granted, in-range access.
    always_comb begin
        bus.gnt0          = gnt0_s;
        bus.gnt1          = gnt1_s;
        bus.mem_address   = {ADDR_W{1'b0}};
        bus.mem_writeData = {DATA_W{1'b0}};
        bus.mem_memWrite  = 1'b0;
        bus.mem_memRead   = 1'b0;
        if (gnt0_s && !oor0_s) begin
            bus.mem_address   = bus.addr0;
            bus.mem_writeData = bus.wdata0;
            bus.mem_memWrite  = bus.we0;
            bus.mem_memRead   = ~bus.we0;
        end else if (gnt1_s && !oor1_s) begin
            bus.mem_address   = bus.addr1;
            bus.mem_writeData = bus.wdata1;
            bus.mem_memWrite  = bus.we1;
            bus.mem_memRead   = ~bus.we1;
        end else begin
            bus.mem_memWrite  = 1'b0;
            bus.mem_memRead   = 1'b0;
        end
    end

    // State registers and one-cycle response tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= UNLOCKED;
            ptr_r      <= 1'b0;
            lock_cnt_r <= CNT_ZERO;
            rd_pend0_r <= 1'b0;
            rd_pend1_r <= 1'b0;
            err0_r     <= 1'b0;
            err1_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            lock_cnt_r <= lock_cnt_s;
            rd_pend0_r <= gnt0_s & ~oor0_s & ~bus.we0;
            rd_pend1_r <= gnt1_s & ~oor1_s & ~bus.we1;
            err0_r     <= gnt0_s & oor0_s;
            err1_r     <= gnt1_s & oor1_s;
        end
    end

    // Response outputs; silenced while reset is held so nothing leaks out.
    always_comb begin
        bus.rvalid0 = 1'b0;
        bus.rvalid1 = 1'b0;
        bus.err0    = 1'b0;
        bus.err1    = 1'b0;
        bus.rdata0  = {DATA_W{1'b0}};
        bus.rdata1  = {DATA_W{1'b0}};
        if (reset) begin
            bus.rvalid0 = 1'b0;
            bus.rvalid1 = 1'b0;
        end else begin
            bus.rvalid0 = rd_pend0_r;
            bus.rvalid1 = rd_pend1_r;
            bus.err0    = err0_r;
            bus.err1    = err1_r;
            if (rd_pend0_r) begin
                bus.rdata0 = bus.mem_readData;
            end else begin
                bus.rdata0 = {DATA_W{1'b0}};
            end
            if (rd_pend1_r) begin
                bus.rdata1 = bus.mem_readData;
            end else begin
                bus.rdata1 = {DATA_W{1'b0}};
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one task per scenario, inline checks.
module tb_mem_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 128;
    localparam int MAX_QW   = 2000;
    localparam int LOCK_MAX = 16;

    localparam logic [DATA_W-1:0] D_Q0    = 128'h0000_00A0;
    localparam logic [DATA_W-1:0] D_Q1    = 128'h0000_00B1;
    localparam logic [DATA_W-1:0] D_Q2000 = 128'h0000_C0DE;
    localparam logic [DATA_W-1:0] D_ZERO  = 128'h0;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [DATA_W-1:0] mem_q [0:2047];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_QW(MAX_QW), .LOCK_MAX(LOCK_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Data memory model: registered read, one-cycle latency, zero when idle.
    always @(posedge clk) begin
        if (reset) begin
            mem_q[0]         <= D_Q0;
            mem_q[1]         <= D_Q1;
            mem_q[2000]      <= D_Q2000;
            bus.mem_readData <= D_ZERO;
        end else begin
            if (bus.mem_memWrite) mem_q[bus.mem_address[14:4]] <= bus.mem_writeData;
            if (bus.mem_memRead) bus.mem_readData <= mem_q[bus.mem_address[14:4]];
            else                 bus.mem_readData <= D_ZERO;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.addr0 = 32'h0; bus.wdata0 = D_ZERO;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.addr1 = 32'h0; bus.wdata1 = D_ZERO;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 128'h55;
        bus.req1 = 1'b1; bus.addr1 = 32'h10;
        tick(); tick(); #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1,
             bus.mem_memWrite, bus.mem_memRead} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000",
                     {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err0, bus.err1,
                      bus.mem_memWrite, bus.mem_memRead});
        end
        checks++;
        if ({bus.mem_address, bus.mem_writeData, bus.rdata0, bus.rdata1} !== {32'h0, D_ZERO, D_ZERO, D_ZERO}) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rdata0 %h rdata1 %h expected all zero",
                     bus.mem_address, bus.mem_writeData, bus.rdata0, bus.rdata1);
        end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_round_robin();
        logic g0;
        logic [1:0] exp_rv;
        logic [2*DATA_W-1:0] exp_rd;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.req0 = 1'b1; bus.addr0 = 32'h00;
            bus.req1 = 1'b1; bus.addr1 = 32'h10;
            #1;
            g0 = ((k % 2) == 0);
            checks++;
            if ({bus.gnt0, bus.gnt1} !== {g0, ~g0}) begin
                errors++;
                $display("FAIL rr_gnt cycle %0d: got %b expected %b", k, {bus.gnt0, bus.gnt1}, {g0, ~g0});
            end
            if (k == 0) begin
                exp_rv = 2'b00;
                exp_rd = {D_ZERO, D_ZERO};
            end else if (g0) begin
                exp_rv = 2'b01;
                exp_rd = {D_ZERO, D_Q1};
            end else begin
                exp_rv = 2'b10;
                exp_rd = {D_Q0, D_ZERO};
            end
            checks++;
            if ({bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1} !== {exp_rv, exp_rd}) begin
                errors++;
                $display("FAIL rr_resp cycle %0d: rvalid %b rdata0 %h rdata1 %h expected %b %h",
                         k, {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1, exp_rv, exp_rd);
            end
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata1} !== {2'b01, D_Q1}) begin
            errors++;
            $display("FAIL rr_last: rvalid %b rdata1 %h expected 01 %h",
                     {bus.rvalid0, bus.rvalid1}, bus.rdata1, D_Q1);
        end
    endtask

    task automatic test_write_read();
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 128'd120;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_memWrite, bus.mem_memRead, bus.mem_address, bus.mem_writeData}
            !== {4'b1010, 32'h20, 128'd120}) begin
            errors++;
            $display("FAIL wr_grant: gnt %b wr %b rd %b addr %h wdata %h expected 10 1 0 20 120",
                     {bus.gnt0, bus.gnt1}, bus.mem_memWrite, bus.mem_memRead, bus.mem_address, bus.mem_writeData);
        end
        tick();
        idle();
        bus.req1 = 1'b1; bus.addr1 = 32'h20;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_memWrite, bus.mem_memRead, bus.mem_address, bus.rvalid0}
            !== {4'b0101, 32'h20, 1'b0}) begin
            errors++;
            $display("FAIL rd_grant: gnt %b wr %b rd %b addr %h rvalid0 %b expected 01 0 1 20 0",
                     {bus.gnt0, bus.gnt1}, bus.mem_memWrite, bus.mem_memRead, bus.mem_address, bus.rvalid0);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1} !== {2'b01, D_ZERO, 128'd120}) begin
            errors++;
            $display("FAIL rd_data: rvalid %b rdata0 %h rdata1 %h expected 01 0 78",
                     {bus.rvalid0, bus.rvalid1}, bus.rdata0, bus.rdata1);
        end
    endtask

    task automatic test_lock();
        tick();
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 32'h00;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL lock_first: gnt %b expected 10", {bus.gnt0, bus.gnt1});
        end
        tick();
        bus.lock0 = 1'b0; bus.addr0 = 32'h10;
        bus.req1 = 1'b1; bus.addr1 = 32'h00;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rdata0} !== {3'b101, D_Q0}) begin
            errors++;
            $display("FAIL lock_hold: gnt %b rvalid0 %b rdata0 %h expected 10 1 %h",
                     {bus.gnt0, bus.gnt1}, bus.rvalid0, bus.rdata0, D_Q0);
        end
        tick();
        bus.req0 = 1'b0;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rdata0} !== {3'b011, D_Q1}) begin
            errors++;
            $display("FAIL lock_release: gnt %b rvalid0 %b rdata0 %h expected 01 1 %h",
                     {bus.gnt0, bus.gnt1}, bus.rvalid0, bus.rdata0, D_Q1);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid1, bus.rdata1} !== {1'b1, D_Q0}) begin
            errors++;
            $display("FAIL lock_rd1: rvalid1 %b rdata1 %h expected 1 %h", bus.rvalid1, bus.rdata1, D_Q0);
        end
    endtask

    task automatic test_lock_timeout();
        int  blocked = 0;
        int  n = 0;
        logic got = 1'b0;
        logic saw_gnt0 = 1'b0;
        tick();
        bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.addr0 = 32'h00;
        #1;
        checks++;
        if (bus.gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL to_lock: gnt0 %b expected 1", bus.gnt0);
        end
        while (!got && n < 40) begin
            tick();
            idle();
            bus.req1 = 1'b1; bus.addr1 = 32'h10;
            #1;
            n++;
            if (bus.gnt0 === 1'b1) saw_gnt0 = 1'b1;
            if (bus.gnt1 === 1'b1) got = 1'b1;
            else blocked++;
        end
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL to_grant: gnt1 seen %b after %0d cycles expected 1", got, n);
        end
        checks++;
        if (blocked != LOCK_MAX) begin
            errors++;
            $display("FAIL to_blocked: got %0d cycles expected %0d", blocked, LOCK_MAX);
        end
        checks++;
        if (saw_gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL to_spurious: gnt0 seen %b expected 0", saw_gnt0);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid1, bus.rdata1} !== {1'b1, D_Q1}) begin
            errors++;
            $display("FAIL to_rd1: rvalid1 %b rdata1 %h expected 1 %h", bus.rvalid1, bus.rdata1, D_Q1);
        end
    endtask

    task automatic test_out_of_range();
        tick();
        bus.req1 = 1'b1; bus.lock1 = 1'b1; bus.addr1 = 32'h7D10;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_memWrite, bus.mem_memRead, bus.mem_address} !== {4'b0100, 32'h0}) begin
            errors++;
            $display("FAIL oor_grant: gnt %b wr %b rd %b addr %h expected 01 0 0 0",
                     {bus.gnt0, bus.gnt1}, bus.mem_memWrite, bus.mem_memRead, bus.mem_address);
        end
        tick();
        idle();
        bus.req0 = 1'b1; bus.addr0 = 32'h7D00;
        #1;
        checks++;
        if ({bus.err1, bus.rvalid1, bus.rdata1, bus.err0} !== {2'b10, D_ZERO, 1'b0}) begin
            errors++;
            $display("FAIL oor_err: err1 %b rvalid1 %b rdata1 %h err0 %b expected 1 0 0 0",
                     bus.err1, bus.rvalid1, bus.rdata1, bus.err0);
        end
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.mem_memRead, bus.mem_address} !== {3'b101, 32'h7D00}) begin
            errors++;
            $display("FAIL oor_edge: gnt %b rd %b addr %h expected 10 1 7d00",
                     {bus.gnt0, bus.gnt1}, bus.mem_memRead, bus.mem_address);
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid0, bus.err0, bus.err1, bus.rdata0} !== {3'b100, D_Q2000}) begin
            errors++;
            $display("FAIL oor_edge_rd: rvalid0 %b err0 %b err1 %b rdata0 %h expected 1 0 0 %h",
                     bus.rvalid0, bus.err0, bus.err1, bus.rdata0, D_Q2000);
        end
    endtask

    task automatic test_reset_pending();
        tick();
        bus.req0 = 1'b1; bus.addr0 = 32'h00;
        #1;
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
            errors++;
            $display("FAIL rp_grant: gnt %b expected 10", {bus.gnt0, bus.gnt1});
        end
        tick();
        idle();
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.rvalid0, bus.rdata0} !== {1'b0, D_ZERO}) begin
            errors++;
            $display("FAIL rp_during: rvalid0 %b rdata0 %h expected 0 0", bus.rvalid0, bus.rdata0);
        end
        tick();
        reset = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 32'h00;
        bus.req1 = 1'b1; bus.addr1 = 32'h10;
        #1;
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.gnt0, bus.gnt1} !== 4'b0010) begin
            errors++;
            $display("FAIL rp_after: rvalid %b gnt %b expected 00 10",
                     {bus.rvalid0, bus.rvalid1}, {bus.gnt0, bus.gnt1});
        end
        tick();
        idle();
        #1;
        checks++;
        if ({bus.rvalid0, bus.rvalid1, bus.rdata0} !== {2'b10, D_Q0}) begin
            errors++;
            $display("FAIL rp_rd: rvalid %b rdata0 %h expected 10 %h",
                     {bus.rvalid0, bus.rvalid1}, bus.rdata0, D_Q0);
        end
    endtask

    // Scenario sequence.
    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_round_robin();
        test_write_read();
        test_lock();
        test_lock_timeout();
        test_out_of_range();
        test_reset_pending();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 128, quadword data width.
REQ-003 SHALL have parameter MAX_QW, default 2000, highest valid quadword index (address>>4).
REQ-004 SHALL have parameter LOCK_MAX, default 16, maximum cycles a lock may be held.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports req0/req1  in  1  access request, held until granted.
REQ-008 SHALL have ports we0/we1  in  1  1 = write, 0 = read.
REQ-009 SHALL have ports lock0/lock1  in  1  keep ownership after this access.
REQ-010 SHALL have ports addr0/addr1  in  ADDR_W  byte address.
REQ-011 SHALL have ports wdata0/wdata1  in  DATA_W  write data.
REQ-012 SHALL have ports gnt0/gnt1  out  1  combinational, request accepted this cycle.
REQ-013 SHALL have ports rvalid0/rvalid1  out  1  read data valid.
REQ-014 SHALL have ports rdata0/rdata1  out  DATA_W  read data.
REQ-015 SHALL have ports err0/err1  out  1  out-of-range access pulse.
REQ-016 SHALL have ports mem_address (ADDR_W), mem_writeData (DATA_W), mem_memWrite (1), mem_memRead (1)  out  drive the data memory.
REQ-017 SHALL have port mem_readData  in  DATA_W  memory read data, registered inside memory, 1-cycle latency, zero when not reading.

Function
REQ-018 SHALL grant at most one requester per cycle; gnt0 and gnt1 never both 1.
REQ-019 SHALL use round-robin: with both requesting and no lock, grant the requester indicated by priority pointer ptr; after any grant, ptr points to the other requester.
REQ-020 SHALL grant a sole requester immediately regardless of ptr (unless locked by the other).
REQ-021 SHALL, in the grant cycle, drive mem_address = granted addr, mem_writeData = granted wdata, mem_memWrite = we, mem_memRead = !we; all mem strobes 0 when no grant.
REQ-022 SHALL, for a granted read in cycle N, assert rvalidN-owner in cycle N+1 with rdata = mem_readData; rdata of a non-valid port = 0.
REQ-023 SHALL treat writes as fire-and-forget: no rvalid, completion at the grant-cycle clock edge.
REQ-024 SHALL, if (addr>>4) > MAX_QW, still grant (consume) the request but assert no mem strobe, pulse errX in cycle N+1 with rvalidX = 0 and rdataX = 0.
REQ-025 SHALL implement states UNLOCKED, LOCKED0, LOCKED1.
REQ-026 SHALL transition UNLOCKED -> LOCKEDn when requester n is granted with lockn = 1.
REQ-027 SHALL, in LOCKEDn, grant only requester n; the other requester waits.
REQ-028 SHALL transition LOCKEDn -> UNLOCKED when requester n is granted with lockn = 0.
REQ-029 SHALL keep a lock-age counter, cleared on entering LOCKEDn, incremented each LOCKEDn cycle; on reaching LOCKED_MAX cycles (count == LOCK_MAX-1), force UNLOCKED next cycle and set ptr to the other requester.
REQ-030 SHALL ignore lockn on an out-of-range (errored) access; no lock taken.
REQ-031 SHALL ignore we/addr/wdata/lock of a requester whose req = 0.

Reset
REQ-032 SHALL, while reset = 1, force gnt*, rvalid*, err*, mem_memWrite, mem_memRead = 0, rdata* = 0, mem_address = 0, mem_writeData = 0.
REQ-033 SHALL on reset set state UNLOCKED, ptr = requester 0, lock counter = 0.
REQ-034 SHALL discard any read response pending across reset: no rvalid in the cycle after reset deasserts.

Verification
REQ-035 Bench SHALL cover: req0 write addr 0x20 data 120 cycle N, req1 read 0x20 cycle N+1 -> gnt0@N, gnt1@N+1, rvalid1@N+2 with rdata1 = 120.
REQ-036 Bench SHALL cover: req0 and req1 both held reading 0x00/0x10 for 4 cycles after reset -> grants 0,1,0,1; rvalid alternating one cycle later.
REQ-037 Bench SHALL cover: req0 lock0=1 read, then req1 and req0 (lock0=0) requesting -> gnt0 twice before gnt1; state back to UNLOCKED.
REQ-038 Bench SHALL cover: req0 with lock0=1 then idle, req1 held -> req1 blocked exactly LOCK_MAX=16 cycles, then gnt1.
REQ-039 Bench SHALL cover: req1 read addr 0x7D10 (index 2001) -> gnt1, no mem strobe, err1@N+1, rvalid1 = 0.
REQ-040 Bench SHALL cover: reset asserted in cycle after a granted read -> no rvalid after release, first subsequent dual request granted to requester 0.
